// File: rtl/iob_picorv32_mem_merge_pkg.sv
// Shared definitions for the PicoRV32 IOb instruction/data bus merge.
package iob_picorv32_mem_merge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_I = 2'd1,
    LOCK_D = 2'd2
  } gnt_state_e;

  localparam logic ID_I = 1'b0;
  localparam logic ID_D = 1'b1;

  // Response bus {rdata, rvalid, ready}, LSB first.
  localparam int RESP_READY_BIT  = 0;
  localparam int RESP_RVALID_BIT = 1;
  localparam int RESP_RDATA_LSB  = 2;

  // Request bus {valid, addr, wdata, wstrb}, LSB first.
  localparam int REQ_WSTRB_LSB = 0;

  function automatic int req_wdata_lsb(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int req_addr_lsb(input int data_w);
    return data_w / 8 + data_w;
  endfunction

  function automatic int req_valid_bit(input int addr_w, input int data_w);
    return addr_w + data_w + data_w / 8;
  endfunction

endpackage

// File: rtl/iob_picorv32_mem_merge_idfifo.sv
// ID FIFO for outstanding reads: 1 bit wide, 2**OUTST_W entries deep.
module iob_picorv32_mem_merge_idfifo #(
  parameter int OUTST_W = 2
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic             cke_i,
  input  logic             push_i,
  input  logic             push_id_i,
  input  logic             pop_i,
  output logic             head_o,
  output logic [OUTST_W:0] count_o,
  output logic             full_o
);
  localparam int DEPTH = 2 ** OUTST_W;
  localparam logic [OUTST_W:0]   FULL_CNT = (OUTST_W + 1)'(DEPTH);
  localparam logic [OUTST_W:0]   CNT_ONE  = (OUTST_W + 1)'(1);
  localparam logic [OUTST_W-1:0] PTR_ONE  = OUTST_W'(1);

  logic [DEPTH-1:0]   r_mem;
  logic [OUTST_W-1:0] r_wptr, r_rptr;
  logic [OUTST_W:0]   r_count;
  logic               w_push, w_pop;

  assign full_o  = (r_count == FULL_CNT);
  assign count_o = r_count;
  assign head_o  = r_mem[r_rptr];
  assign w_push  = cke_i && push_i && !full_o;
  assign w_pop   = cke_i && pop_i && (r_count != '0);

  // NOTE: storage needs no reset; the pointers and count alone decide which entries are live.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= push_id_i;
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/iob_picorv32_mem_merge.sv
// Merges PicoRV32 instruction and data IOb buses onto one memory port.
// Define IOB_MERGE_RR_EN for round-robin tie-break; default gives D fixed priority.
module iob_picorv32_mem_merge
  import iob_picorv32_mem_merge_pkg::*;
#(
  parameter  int ADDR_W  = 32,
  parameter  int DATA_W  = 32,
  parameter  int OUTST_W = 2,
  localparam int REQ_W   = 1 + ADDR_W + DATA_W + DATA_W / 8,
  localparam int RESP_W  = DATA_W + 2
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              cke_i,
  input  logic [REQ_W-1:0]  ibus_req_i,
  output logic [RESP_W-1:0] ibus_resp_o,
  input  logic [REQ_W-1:0]  dbus_req_i,
  output logic [RESP_W-1:0] dbus_resp_o,
  output logic [REQ_W-1:0]  mem_req_o,
  input  logic [RESP_W-1:0] mem_resp_i,
  output logic              err_o
);
  localparam int VALID_BIT = req_valid_bit(ADDR_W, DATA_W);
  localparam int STRB_W    = DATA_W / 8;

  gnt_state_e       r_state, w_state_nxt;
  logic             w_i_valid, w_d_valid, w_gnt_i, w_gnt_d, w_tie_i;
  logic             w_rdy, w_acc, w_acc_read, w_acc_id;
  logic             w_full, w_head, w_push, w_pop, w_rsp_ok, r_err;
  logic [OUTST_W:0] w_count;
  logic [REQ_W-1:0] w_gnt_req;
  logic [DATA_W-1:0] w_rdata;

  assign w_i_valid = ibus_req_i[VALID_BIT];
  assign w_d_valid = dbus_req_i[VALID_BIT];
  assign w_rdy     = mem_resp_i[RESP_READY_BIT] && !w_full;

`ifdef IOB_MERGE_RR_EN
  logic r_last;
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i)            r_last <= ID_D;
    else if (cke_i && w_acc)  r_last <= w_acc_id;
  end
  assign w_tie_i = (r_last == ID_D);
`else
  assign w_tie_i = 1'b0;
`endif

  // A grant that is not accepted locks until accepted or withdrawn.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    w_state_nxt = r_state;
    w_gnt_i     = 1'b0;
    w_gnt_d     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_i_valid && (!w_d_valid || w_tie_i)) w_gnt_i = 1'b1;
        else if (w_d_valid)                       w_gnt_d = 1'b1;
        if ((w_gnt_i || w_gnt_d) && !w_rdy) w_state_nxt = w_gnt_i ? LOCK_I : LOCK_D;
      end
      LOCK_I: begin
        w_gnt_i = 1'b1;
        if (w_rdy || !w_i_valid) w_state_nxt = IDLE;
      end
      LOCK_D: begin
        w_gnt_d = 1'b1;
        if (w_rdy || !w_d_valid) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i)  r_state <= IDLE;
    else if (cke_i) r_state <= w_state_nxt;
  end

  assign w_gnt_req  = w_gnt_i ? ibus_req_i : (w_gnt_d ? dbus_req_i : '0);
  assign mem_req_o  = w_full ? '0 : w_gnt_req;
  assign w_acc      = w_gnt_req[VALID_BIT] && w_rdy;
  assign w_acc_read = (w_gnt_req[REQ_WSTRB_LSB +: STRB_W] == '0);
  assign w_acc_id   = w_gnt_d ? ID_D : ID_I;
  assign w_push     = w_acc && w_acc_read;
  assign w_pop      = mem_resp_i[RESP_RVALID_BIT];

  iob_picorv32_mem_merge_idfifo #(.OUTST_W(OUTST_W)) u_idfifo (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .cke_i    (cke_i),
    .push_i   (w_push),
    .push_id_i(w_acc_id),
    .pop_i    (w_pop),
    .head_o   (w_head),
    .count_o  (w_count),
    .full_o   (w_full)
  );

  // An rvalid with nothing outstanding is dropped and flagged.
  assign w_rsp_ok    = w_pop && (w_count != '0);
  assign w_rdata     = mem_resp_i[RESP_W-1:RESP_RDATA_LSB];
  assign ibus_resp_o = {w_rdata, w_rsp_ok && (w_head == ID_I), w_gnt_i && w_rdy};
  assign dbus_resp_o = {w_rdata, w_rsp_ok && (w_head == ID_D), w_gnt_d && w_rdy};

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i)                         r_err <= 1'b0;
    else if (cke_i && w_pop && !w_rsp_ok)  r_err <= 1'b1;
  end
  assign err_o = r_err;

endmodule

// File: tb/tb_iob_picorv32_mem_merge.sv
// Self-checking bench for iob_picorv32_mem_merge: directed scenarios plus random traffic vs a queue model.
module tb_iob_picorv32_mem_merge;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int OUTST_W = 2;
  localparam int REQ_W   = 1 + ADDR_W + DATA_W + DATA_W / 8;
  localparam int RESP_W  = DATA_W + 2;
  localparam int STRB_W  = DATA_W / 8;
  localparam int DEPTH   = 2 ** OUTST_W;
`ifdef IOB_MERGE_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              arst_n_i = 1'b0;
  logic              cke_i = 1'b1;
  logic [REQ_W-1:0]  ibus_req_i = '0;
  logic [REQ_W-1:0]  dbus_req_i = '0;
  logic [RESP_W-1:0] mem_resp_i = '0;
  logic [RESP_W-1:0] ibus_resp_o, dbus_resp_o;
  logic [REQ_W-1:0]  mem_req_o;
  logic              err_o;

  iob_picorv32_mem_merge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .OUTST_W(OUTST_W)) dut (
    .clk_i      (clk_i),
    .arst_n_i   (arst_n_i),
    .cke_i      (cke_i),
    .ibus_req_i (ibus_req_i),
    .ibus_resp_o(ibus_resp_o),
    .dbus_req_i (dbus_req_i),
    .dbus_resp_o(dbus_resp_o),
    .mem_req_o  (mem_req_o),
    .mem_resp_i (mem_resp_i),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_err = 0;
  int n_chk = 0;

  // Model: outstanding read owners (0=I, 1=D), locked owner (-1 none), last served, sticky error.
  int q[$];
  int lock_owner = -1;
  int last = 1;
  bit m_err = 1'b0;
  int gnt;
  bit gvalid, rdy, acc, acc_read, rsp_ok;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [REQ_W-1:0] mk_req(input bit v, input logic [31:0] a,
                                             input logic [31:0] d, input logic [3:0] s);
    return {v, a, d, s};
  endfunction

  function automatic logic [RESP_W-1:0] mk_resp(input logic [31:0] d, input bit rv, input bit rd);
    return {d, rv, rd};
  endfunction

  task automatic eval_and_check();
    bit iv, dv, stall;
    int head;
    logic [REQ_W-1:0]  greq, e_mem;
    logic [DATA_W-1:0] rdata;
    #3;
    iv    = ibus_req_i[REQ_W-1];
    dv    = dbus_req_i[REQ_W-1];
    stall = (q.size() == DEPTH);
    if (lock_owner >= 0)  gnt = lock_owner;
    else if (iv && dv)    gnt = (RR_EN && last == 1) ? 0 : 1;
    else if (iv)          gnt = 0;
    else if (dv)          gnt = 1;
    else                  gnt = -1;
    rdy      = mem_resp_i[0] && !stall;
    gvalid   = (gnt == 0) ? iv : ((gnt == 1) ? dv : 1'b0);
    acc      = gvalid && rdy;
    greq     = (gnt == 0) ? ibus_req_i : ((gnt == 1) ? dbus_req_i : '0);
    acc_read = (greq[STRB_W-1:0] == '0);
    e_mem    = (stall || gnt < 0) ? '0 : greq;
    head     = (q.size() > 0) ? q[0] : -1;
    rsp_ok   = mem_resp_i[1] && head >= 0;
    rdata    = mem_resp_i[RESP_W-1:2];
    check("mem_req", mem_req_o, e_mem);
    check("ibus_resp", ibus_resp_o, {rdata, rsp_ok && head == 0, gnt == 0 && rdy});
    check("dbus_resp", dbus_resp_o, {rdata, rsp_ok && head == 1, gnt == 1 && rdy});
    check("err", err_o, m_err);
  endtask

  task automatic model_update();
    if (!cke_i) return;
    if (rsp_ok) void'(q.pop_front());
    else if (mem_resp_i[1]) m_err = 1'b1;
    if (acc && acc_read) q.push_back(gnt);
    if (acc) last = gnt;
    lock_owner = (gnt >= 0 && gvalid && !rdy) ? gnt : -1;
  endtask

  task automatic cyc_begin(input logic [REQ_W-1:0] ir, input logic [REQ_W-1:0] dr,
                           input logic [RESP_W-1:0] mr);
    ibus_req_i = ir;
    dbus_req_i = dr;
    mem_resp_i = mr;
    eval_and_check();
  endtask

  task automatic step_end();
    model_update();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    arst_n_i   = 1'b0;
    cke_i      = 1'b1;
    ibus_req_i = '0;
    dbus_req_i = '0;
    mem_resp_i = '0;
    #2;
    q.delete();
    lock_owner = -1;
    last       = 1;
    m_err      = 1'b0;
    arst_n_i   = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic [REQ_W-1:0] wi, wd, ri;
    bit iv, dv, iw, dw, rv;

    // Reset state and single instruction read with routed response.
    do_reset();
    cyc_begin('0, '0, '0);
    check("rst_err", err_o, 0);
    check("rst_mem_req", mem_req_o, 0);
    check("rst_ibus_resp", ibus_resp_o, 0);
    step_end();
    cyc_begin(mk_req(1, 32'h100, 0, 0), '0, mk_resp(0, 0, 1));
    check("t1_mem_req", mem_req_o, mk_req(1, 32'h100, 0, 0));
    check("t1_i_ready", ibus_resp_o[0], 1);
    check("t1_d_ready", dbus_resp_o[0], 0);
    step_end();
    cyc_begin('0, '0, '0);
    step_end();
    cyc_begin('0, '0, mk_resp(32'hDEADBEEF, 1, 0));
    check("t1_ibus_rsp", ibus_resp_o, mk_resp(32'hDEADBEEF, 1, 0));
    check("t1_dbus_rsp", dbus_resp_o, mk_resp(32'hDEADBEEF, 0, 0));
    check("t1_err", err_o, 0);
    step_end();
    cyc_begin('0, '0, '0);
    check("t1_err_after", err_o, 0);
    step_end();

    // Simultaneous requests.
    do_reset();
    wi = mk_req(1, 32'h200, 32'h11, 4'hF);
    wd = mk_req(1, 32'h300, 32'h22, 4'hF);
    cyc_begin(wi, wd, mk_resp(0, 0, 1));
    check("t2_first", mem_req_o, RR_EN ? wi : wd);
    check("t2_first_i_ready", ibus_resp_o[0], RR_EN ? 1 : 0);
    step_end();
    cyc_begin(RR_EN ? '0 : wi, RR_EN ? wd : '0, mk_resp(0, 0, 1));
    check("t2_second", mem_req_o, RR_EN ? wd : wi);
    step_end();

    // D write held off by mem ready while I waits; then I read.
    do_reset();
    wd = mk_req(1, 32'h400, 32'h33, 4'h3);
    ri = mk_req(1, 32'h500, 0, 0);
    cyc_begin('0, wd, mk_resp(0, 0, 0));
    check("t3_c1_mem", mem_req_o, wd);
    check("t3_c1_d_ready", dbus_resp_o[0], 0);
    step_end();
    for (int c = 2; c <= 3; c++) begin
      cyc_begin(ri, wd, mk_resp(0, 0, 0));
      check("t3_lock_mem", mem_req_o, wd);
      check("t3_lock_i_ready", ibus_resp_o[0], 0);
      step_end();
    end
    cyc_begin(ri, wd, mk_resp(0, 0, 1));
    check("t3_c4_mem", mem_req_o, wd);
    check("t3_c4_d_ready", dbus_resp_o[0], 1);
    check("t3_c4_i_ready", ibus_resp_o[0], 0);
    step_end();
    cyc_begin(ri, '0, mk_resp(0, 0, 1));
    check("t3_c5_i_ready", ibus_resp_o[0], 1);
    step_end();
    cyc_begin('0, '0, mk_resp(32'h5, 1, 0));
    check("t3_rsp_i", ibus_resp_o[1], 1);
    check("t3_rsp_d", dbus_resp_o[1], 0);
    step_end();

    // Fill the FIFO, stall, then drain in order; then an unmatched rvalid.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      ri = mk_req(1, 32'h600 + 32'(4 * k), 0, 0);
      cyc_begin((k % 2 == 0) ? ri : '0, (k % 2 == 1) ? ri : '0, mk_resp(0, 0, 1));
      check("t4_fill_ready", (k % 2 == 0) ? ibus_resp_o[0] : dbus_resp_o[0], 1);
      step_end();
    end
    cyc_begin(mk_req(1, 32'h700, 0, 0), '0, mk_resp(0, 0, 1));
    check("t4_stall_mem", mem_req_o, 0);
    check("t4_stall_i_ready", ibus_resp_o[0], 0);
    step_end();
    cyc_begin('0, mk_req(1, 32'h704, 32'h1, 4'h1), mk_resp(0, 0, 1));
    check("t4_stall_wr_mem", mem_req_o, 0);
    check("t4_stall_d_ready", dbus_resp_o[0], 0);
    step_end();
    for (int k = 0; k < 4; k++) begin
      cyc_begin('0, '0, mk_resp(32'hA0 + 32'(k), 1, 0));
      check("t4_drain_i", ibus_resp_o[1], (k % 2 == 0) ? 1 : 0);
      check("t4_drain_d", dbus_resp_o[1], (k % 2 == 1) ? 1 : 0);
      step_end();
    end
    cyc_begin('0, '0, mk_resp(32'hBAD, 1, 0));
    check("t5_drop_i", ibus_resp_o[1], 0);
    check("t5_drop_d", dbus_resp_o[1], 0);
    step_end();
    for (int k = 0; k < 3; k++) begin
      cyc_begin('0, '0, '0);
      check("t5_err_sticky", err_o, 1);
      step_end();
    end
    do_reset();
    cyc_begin('0, '0, '0);
    check("t5_err_cleared", err_o, 0);
    step_end();

    // Reset with reads outstanding drops their responses.
    for (int k = 0; k < 2; k++) begin
      cyc_begin(mk_req(1, 32'h800 + 32'(4 * k), 0, 0), '0, mk_resp(0, 0, 1));
      step_end();
    end
    do_reset();
    cyc_begin('0, '0, mk_resp(32'h77, 1, 0));
    check("t6_no_rvalid", ibus_resp_o[1], 0);
    step_end();
    cyc_begin('0, '0, '0);
    check("t6_err", err_o, 1);
    step_end();

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      iv = 1'($urandom_range(0, 1));
      dv = 1'($urandom_range(0, 1));
      iw = ($urandom_range(0, 2) == 0);
      dw = ($urandom_range(0, 2) == 0);
      rv = (q.size() > 0) ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 2);
      cke_i = ($urandom_range(0, 7) != 0);
      cyc_begin(mk_req(iv, $urandom, $urandom, iw ? 4'($urandom_range(1, 15)) : 4'h0),
                mk_req(dv, $urandom, $urandom, dw ? 4'($urandom_range(1, 15)) : 4'h0),
                mk_resp($urandom, rv, $urandom_range(0, 3) != 0));
      step_end();
    end
    cke_i = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
